// File: rtl/tipi_link_fifo.sv
// TI<->RPi mailbox: NUM_CH channels, each with a DEPTH-entry TI->RPi FIFO and an RPi->TI
// receive register, driven on the RPi side by a synchronised serial shift/latch protocol.
module tipi_link_fifo #(
  parameter int DATA_W      = 8,
  parameter int NUM_CH      = 2,
  parameter int CH_W        = 1,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  input  logic              ti_wr_stb,
  input  logic              ti_rd_stb,
  input  logic [CH_W-1:0]   ti_ch,
  input  logic [DATA_W-1:0] ti_din,
  output logic [DATA_W-1:0] ti_dout,
  output logic [NUM_CH-1:0] t_full,
  output logic [NUM_CH-1:0] t_empty,
  output logic [NUM_CH-1:0] r_valid,
  input  logic              r_clk,
  input  logic              r_le,
  input  logic              r_rt,
  input  logic [CH_W-1:0]   r_ch,
  input  logic              r_dout,
  output logic              r_din
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = CH_W + 4;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // All RPi pins travel through one shared chain so they stay mutually aligned.
  logic [SYNC_STAGES-1:0][SW-1:0] sync_q, sync_d;
  logic [SW-1:0]   pins_s;
  logic            clk_prev_q, le_prev_q;
  logic            s_clk, s_le, s_rt, s_dout;
  logic [CH_W-1:0] s_ch;
  logic            le_rise, clk_rise;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = {r_clk, r_le, r_rt, r_ch, r_dout};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      clk_prev_q <= 1'b0;
      le_prev_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      clk_prev_q <= s_clk;
      le_prev_q  <= s_le;
    end
  end

  assign pins_s   = sync_q[SYNC_STAGES-1];
  assign s_clk    = pins_s[CH_W+3];
  assign s_le     = pins_s[CH_W+2];
  assign s_rt     = pins_s[CH_W+1];
  assign s_ch     = pins_s[CH_W:1];
  assign s_dout   = pins_s[0];
  assign le_rise  = s_le & ~le_prev_q;
  assign clk_rise = s_clk & ~clk_prev_q & ~s_le;

  logic [NUM_CH-1:0]             push, pop, latch;
  logic [NUM_CH-1:0]             full_d, empty_d;
  logic [NUM_CH-1:0][DATA_W-1:0] load_val;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam logic [CH_W-1:0] CH_ID = CH_W'(gi);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [DATA_W-1:0] last_q, last_d, head;
    logic              sel_r, sel_t;

    assign sel_r = (s_ch == CH_ID);
    assign sel_t = (ti_ch == CH_ID);
    assign head  = mem_q[rd_ptr_q];

    // A pop on a full FIFO frees the slot a same-cycle push needs.
    assign pop[gi]      = enable & le_rise & s_rt & sel_r & (count_q != '0);
    assign push[gi]     = enable & ti_wr_stb & sel_t & ((count_q != DEPTH_C) | pop[gi]);
    assign latch[gi]    = enable & le_rise & ~s_rt & sel_r;
    assign load_val[gi] = pop[gi] ? head : last_q;

    always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      last_d   = last_q;
      if (!enable) begin
        rd_ptr_d = '0;
        wr_ptr_d = '0;
        count_d  = '0;
        last_d   = '0;
      end else begin
        if (pop[gi]) begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          last_d   = head;
        end
        if (push[gi]) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (push[gi] && !pop[gi]) begin
          count_d = count_q + CW'(1);
        end else if (pop[gi] && !push[gi]) begin
          count_d = count_q - CW'(1);
        end
      end
    end

    assign full_d[gi]  = (count_d == DEPTH_C);
    assign empty_d[gi] = (count_d == '0);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        count_q  <= '0;
        last_q   <= '0;
      end else begin
        rd_ptr_q <= rd_ptr_d;
        wr_ptr_q <= wr_ptr_d;
        count_q  <= count_d;
        last_q   <= last_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push[gi]) begin
        mem_q[wr_ptr_q] <= ti_din;
      end
    end
  end

  logic [DATA_W-1:0]             tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0]             rx_shift_q, rx_shift_d;
  logic [NUM_CH-1:0][DATA_W-1:0] rx_reg_q, rx_reg_d;
  logic [NUM_CH-1:0]             r_valid_q, r_valid_d;
  logic [NUM_CH-1:0]             t_full_q, t_empty_q;
  logic [DATA_W-1:0]             ti_dout_q, ti_dout_d;
  logic                          r_din_q, r_din_d;

  always_comb begin
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_reg_d   = rx_reg_q;
    r_valid_d  = r_valid_q;
    r_din_d    = r_din_q;
    ti_dout_d  = '0;
    if (!enable) begin
      rx_reg_d  = '0;
      r_valid_d = '0;
    end else begin
      if (clk_rise) begin
        if (s_rt) begin
          tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
          r_din_d    = tx_shift_q[DATA_W-2];
        end else begin
          rx_shift_d = {rx_shift_q[DATA_W-2:0], s_dout};
          r_din_d    = ^{rx_shift_q[DATA_W-2:0], s_dout};
        end
      end
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (le_rise && s_rt && (s_ch == CH_W'(ch))) begin
          tx_shift_d = load_val[ch];
          r_din_d    = load_val[ch][DATA_W-1];
        end
        // Latch is applied after the read clear so a coincident latch keeps r_valid set.
        if (ti_rd_stb && (ti_ch == CH_W'(ch))) begin
          r_valid_d[ch] = 1'b0;
        end
        if (latch[ch]) begin
          rx_reg_d[ch]  = rx_shift_q;
          r_valid_d[ch] = 1'b1;
        end
      end
    end
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (ti_ch == CH_W'(ch)) begin
        ti_dout_d = rx_reg_q[ch];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_reg_q   <= '0;
      r_valid_q  <= '0;
      t_full_q   <= '0;
      t_empty_q  <= '1;
      ti_dout_q  <= '0;
      r_din_q    <= 1'b0;
    end else begin
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_reg_q   <= rx_reg_d;
      r_valid_q  <= r_valid_d;
      t_full_q   <= full_d;
      t_empty_q  <= empty_d;
      ti_dout_q  <= ti_dout_d;
      r_din_q    <= r_din_d;
    end
  end

  assign ti_dout = ti_dout_q;
  assign t_full  = t_full_q;
  assign t_empty = t_empty_q;
  assign r_valid = r_valid_q;
  assign r_din   = r_din_q;

endmodule

// File: tb/tb_tipi_link_fifo.sv
// Bench for tipi_link_fifo: directed scenarios plus a random phase, all checked against
// a queue-based mailbox model.
module tb_tipi_link_fifo;

  localparam int DATA_W = 8;
  localparam int NUM_CH = 2;
  localparam int CH_W   = 1;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic              ti_wr_stb;
  logic              ti_rd_stb;
  logic [CH_W-1:0]   ti_ch;
  logic [DATA_W-1:0] ti_din;
  logic [DATA_W-1:0] ti_dout;
  logic [NUM_CH-1:0] t_full;
  logic [NUM_CH-1:0] t_empty;
  logic [NUM_CH-1:0] r_valid;
  logic              r_clk;
  logic              r_le;
  logic              r_rt;
  logic [CH_W-1:0]   r_ch;
  logic              r_dout;
  logic              r_din;

  tipi_link_fifo #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .DEPTH(DEPTH), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .ti_wr_stb(ti_wr_stb), .ti_rd_stb(ti_rd_stb), .ti_ch(ti_ch), .ti_din(ti_din),
    .ti_dout(ti_dout), .t_full(t_full), .t_empty(t_empty), .r_valid(r_valid),
    .r_clk(r_clk), .r_le(r_le), .r_rt(r_rt), .r_ch(r_ch), .r_dout(r_dout), .r_din(r_din)
  );

  always #5 clk = ~clk;

  // Mailbox model
  logic [7:0]        q_m [NUM_CH][$];
  logic [7:0]        last_m [NUM_CH];
  logic [7:0]        rxreg_m [NUM_CH];
  logic [7:0]        tx_m, rx_m;
  logic [NUM_CH-1:0] valid_m;
  logic              rdin_m;

  int errors = 0;
  int checks = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      q_m[c].delete();
      last_m[c]  = 8'h00;
      rxreg_m[c] = 8'h00;
    end
    tx_m    = 8'h00;
    rx_m    = 8'h00;
    valid_m = '0;
    rdin_m  = 1'b0;
  endtask

  task automatic ti_write(input int ch, input logic [7:0] d);
    ti_ch = CH_W'(ch);
    ti_din = d;
    ti_wr_stb = 1'b1;
    tick(1);
    ti_wr_stb = 1'b0;
    if (enable && q_m[ch].size() < DEPTH) q_m[ch].push_back(d);
    checks++;
    if (t_full[ch] !== (q_m[ch].size() == DEPTH) || t_empty[ch] !== (q_m[ch].size() == 0)) begin
      errors++;
      $display("FAIL write_flags ch%0d data=%02h: full/empty got %b/%b want %b/%b", ch, d,
               t_full[ch], t_empty[ch], q_m[ch].size() == DEPTH, q_m[ch].size() == 0);
    end
    $display("ti_write ch%0d data=%02h level=%0d", ch, d, q_m[ch].size());
  endtask

  task automatic rpi_pop(input int ch, output logic [7:0] got);
    r_rt = 1'b1;
    r_ch = CH_W'(ch);
    tick(5);
    r_le = 1'b1;
    tick(5);
    tx_m = (q_m[ch].size() != 0) ? q_m[ch].pop_front() : last_m[ch];
    last_m[ch] = tx_m;
    rdin_m = tx_m[7];
    got[7] = r_din;
    checks++;
    if (r_din !== rdin_m || t_empty[ch] !== (q_m[ch].size() == 0) ||
        t_full[ch] !== (q_m[ch].size() == DEPTH)) begin
      errors++;
      $display("FAIL pop_load ch%0d: r_din/empty/full got %b/%b/%b want %b/%b/%b", ch,
               r_din, t_empty[ch], t_full[ch], rdin_m, q_m[ch].size() == 0, q_m[ch].size() == DEPTH);
    end
    r_le = 1'b0;
    tick(5);
    for (int i = 0; i < 7; i++) begin
      r_clk = 1'b1;
      tick(5);
      tx_m = tx_m << 1;
      rdin_m = tx_m[7];
      got[6-i] = r_din;
      checks++;
      if (r_din !== rdin_m) begin
        errors++;
        $display("FAIL pop_bit ch%0d bit%0d: r_din got %b want %b", ch, i + 1, r_din, rdin_m);
      end
      r_clk = 1'b0;
      tick(5);
    end
    $display("rpi_pop ch%0d word=%02h level=%0d", ch, got, q_m[ch].size());
  endtask

  task automatic rpi_shift_in(input int ch, input logic [7:0] w);
    r_rt = 1'b0;
    r_ch = CH_W'(ch);
    tick(5);
    for (int i = 7; i >= 0; i--) begin
      r_dout = w[i];
      r_clk = 1'b1;
      tick(5);
      rx_m = {rx_m[6:0], w[i]};
      rdin_m = ^rx_m;
      checks++;
      if (r_din !== rdin_m) begin
        errors++;
        $display("FAIL rx_parity bit%0d of %02h: r_din got %b want %b", 7 - i, w, r_din, rdin_m);
      end
      r_clk = 1'b0;
      tick(5);
    end
    $display("rpi_shift_in word=%02h", w);
  endtask

  task automatic rpi_latch(input int ch);
    r_rt = 1'b0;
    r_ch = CH_W'(ch);
    tick(5);
    r_le = 1'b1;
    tick(5);
    rxreg_m[ch] = rx_m;
    valid_m[ch] = 1'b1;
    checks++;
    if (r_valid !== valid_m) begin
      errors++;
      $display("FAIL latch_valid ch%0d: r_valid got %b want %b", ch, r_valid, valid_m);
    end
    r_le = 1'b0;
    tick(5);
    $display("rpi_latch ch%0d word=%02h", ch, rx_m);
  endtask

  task automatic ti_read(input int ch);
    ti_ch = CH_W'(ch);
    ti_rd_stb = 1'b1;
    tick(1);
    ti_rd_stb = 1'b0;
    valid_m[ch] = 1'b0;
    checks++;
    if (r_valid !== valid_m || ti_dout !== rxreg_m[ch]) begin
      errors++;
      $display("FAIL ti_read ch%0d: r_valid/ti_dout got %b/%02h want %b/%02h", ch,
               r_valid, ti_dout, valid_m, rxreg_m[ch]);
    end
    $display("ti_read ch%0d dout=%02h", ch, ti_dout);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    model_reset();
    checks++;
    if (r_din !== 1'b0 || ti_dout !== 8'h00 || t_full !== 2'b00 || t_empty !== 2'b11 || r_valid !== 2'b00) begin
      errors++;
      $display("FAIL reset_state: din=%b dout=%02h full=%b empty=%b valid=%b want 0/00/00/11/00",
               r_din, ti_dout, t_full, t_empty, r_valid);
    end
    reset_n = 1'b1;
    tick(2);
    $display("test_reset done");
  endtask

  task automatic test_tx_shift();
    logic [7:0] got;
    ti_write(1, 8'hA5);
    ti_write(1, 8'h3C);
    rpi_pop(1, got);
    checks++;
    if (got !== 8'hA5 || t_empty[1] !== 1'b0) begin
      errors++;
      $display("FAIL tx_first: word/empty got %02h/%b want a5/0", got, t_empty[1]);
    end
    rpi_pop(1, got);
    checks++;
    if (got !== 8'h3C || t_empty[1] !== 1'b1) begin
      errors++;
      $display("FAIL tx_second: word/empty got %02h/%b want 3c/1", got, t_empty[1]);
    end
  endtask

  task automatic test_rx_shift();
    rpi_shift_in(0, 8'h81);
    rpi_latch(0);
    ti_ch = 1'b1;
    tick(2);
    ti_ch = 1'b0;
    tick(1);
    checks++;
    if (ti_dout !== 8'h81) begin
      errors++;
      $display("FAIL rx_dout_latency: ti_dout got %02h want 81", ti_dout);
    end
    ti_read(0);
  endtask

  task automatic test_fifo_full();
    logic [7:0] got;
    for (int i = 1; i <= 5; i++) ti_write(0, 8'(i));
    checks++;
    if (t_full[0] !== 1'b1) begin
      errors++;
      $display("FAIL full_flag: t_full[0] got %b want 1", t_full[0]);
    end
    for (int i = 1; i <= 5; i++) begin
      rpi_pop(0, got);
      checks++;
      if (got !== 8'((i == 5) ? 4 : i)) begin
        errors++;
        $display("FAIL full_drain pop%0d: word got %02h want %02h", i, got, 8'((i == 5) ? 4 : i));
      end
    end
  endtask

  // TI write lands in exactly the clk the synchronised LE rise is acted on.
  task automatic coincident_push_pop(input int ch, input logic [7:0] w);
    r_rt = 1'b1;
    r_ch = CH_W'(ch);
    tick(5);
    r_le = 1'b1;
    tick(2);
    ti_ch = CH_W'(ch);
    ti_din = w;
    ti_wr_stb = 1'b1;
    tick(1);
    ti_wr_stb = 1'b0;
    tx_m = (q_m[ch].size() != 0) ? q_m[ch].pop_front() : last_m[ch];
    last_m[ch] = tx_m;
    rdin_m = tx_m[7];
    q_m[ch].push_back(w);
    checks++;
    if (r_din !== rdin_m || t_full[ch] !== (q_m[ch].size() == DEPTH) || t_empty[ch] !== 1'b0) begin
      errors++;
      $display("FAIL push_pop ch%0d: din/full/empty got %b/%b/%b want %b/%b/0", ch,
               r_din, t_full[ch], t_empty[ch], rdin_m, q_m[ch].size() == DEPTH);
    end
    r_le = 1'b0;
    tick(5);
    $display("push_pop ch%0d popped=%02h pushed=%02h level=%0d", ch, tx_m, w, q_m[ch].size());
  endtask

  task automatic test_full_push_pop();
    logic [7:0] got;
    logic [7:0] w;
    for (int i = 0; i < DEPTH; i++) ti_write(0, 8'($urandom));
    w = 8'($urandom);
    coincident_push_pop(0, w);
    for (int i = 0; i < DEPTH; i++) rpi_pop(0, got);
    checks++;
    if (got !== w) begin
      errors++;
      $display("FAIL full_tail: last word got %02h want %02h", got, w);
    end
    w = 8'($urandom);
    coincident_push_pop(1, w);
    rpi_pop(1, got);
    checks++;
    if (got !== w) begin
      errors++;
      $display("FAIL empty_push_lands: word got %02h want %02h", got, w);
    end
  endtask

  task automatic test_rd_latch_same();
    rpi_shift_in(1, 8'($urandom));
    r_rt = 1'b0;
    r_ch = 1'b1;
    tick(5);
    r_le = 1'b1;
    tick(2);
    ti_ch = 1'b1;
    ti_rd_stb = 1'b1;
    tick(1);
    ti_rd_stb = 1'b0;
    rxreg_m[1] = rx_m;
    valid_m[1] = 1'b1;
    checks++;
    if (r_valid[1] !== 1'b1) begin
      errors++;
      $display("FAIL rd_latch_valid: r_valid[1] got %b want 1", r_valid[1]);
    end
    tick(1);
    checks++;
    if (ti_dout !== rxreg_m[1]) begin
      errors++;
      $display("FAIL rd_latch_dout: ti_dout got %02h want %02h", ti_dout, rxreg_m[1]);
    end
    r_le = 1'b0;
    tick(5);
    $display("rd_latch_same word=%02h", rxreg_m[1]);
  endtask

  task automatic test_random();
    logic [7:0] got;
    int ch;
    for (int n = 0; n < 40; n++) begin
      ch = $urandom_range(0, NUM_CH - 1);
      case ($urandom_range(0, 3))
        0: ti_write(ch, 8'($urandom));
        1: rpi_pop(ch, got);
        2: begin
          rpi_shift_in(ch, 8'($urandom));
          rpi_latch(ch);
        end
        default: ti_read(ch);
      endcase
    end
  endtask

  task automatic test_enable();
    ti_write(0, 8'h11);
    ti_write(1, 8'h22);
    rpi_shift_in(0, 8'h5A);
    rpi_latch(0);
    enable = 1'b0;
    tick(2);
    for (int c = 0; c < NUM_CH; c++) q_m[c].delete();
    ti_write(0, 8'h33);
    checks++;
    if (t_empty !== 2'b11 || t_full !== 2'b00 || r_valid !== 2'b00 || r_din !== rdin_m) begin
      errors++;
      $display("FAIL disable_clear: empty/full/valid/din got %b/%b/%b/%b want 11/00/00/%b",
               t_empty, t_full, r_valid, r_din, rdin_m);
    end
    enable = 1'b1;
    tick(1);
    model_reset_after_disable();
    ti_write(1, 8'h6E);
    begin
      logic [7:0] got;
      rpi_pop(1, got);
      checks++;
      if (got !== 8'h6E) begin
        errors++;
        $display("FAIL reenable_pop: word got %02h want 6e", got);
      end
    end
  endtask

  task automatic model_reset_after_disable();
    for (int c = 0; c < NUM_CH; c++) begin
      q_m[c].delete();
      last_m[c]  = 8'h00;
      rxreg_m[c] = 8'h00;
    end
    valid_m = '0;
  endtask

  task automatic test_reset_mid_shift();
    logic [7:0] got;
    ti_write(1, 8'hFF);
    r_rt = 1'b1;
    r_ch = 1'b1;
    tick(5);
    r_le = 1'b1;
    tick(5);
    tx_m = q_m[1].pop_front();
    r_le = 1'b0;
    tick(5);
    for (int i = 0; i < 3; i++) begin
      r_clk = 1'b1;
      tick(5);
      r_clk = 1'b0;
      tick(5);
    end
    checks++;
    if (r_din !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_din: r_din got %b want 1", r_din);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (r_din !== 1'b0 || t_empty !== 2'b11 || t_full !== 2'b00 || r_valid !== 2'b00) begin
      errors++;
      $display("FAIL async_reset: din/empty/full/valid got %b/%b/%b/%b want 0/11/00/00",
               r_din, t_empty, t_full, r_valid);
    end
    tick(2);
    model_reset();
    reset_n = 1'b1;
    tick(2);
    rpi_pop(1, got);
    checks++;
    if (got !== 8'h00) begin
      errors++;
      $display("FAIL post_reset_load: word got %02h want 00", got);
    end
  endtask

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b1;
    ti_wr_stb = 1'b0;
    ti_rd_stb = 1'b0;
    ti_ch     = '0;
    ti_din    = '0;
    r_clk     = 1'b0;
    r_le      = 1'b0;
    r_rt      = 1'b0;
    r_ch      = '0;
    r_dout    = 1'b0;
    model_reset();
    test_reset();
    test_tx_shift();
    test_rx_shift();
    test_fifo_full();
    test_full_push_pop();
    test_rd_latch_same();
    test_random();
    test_enable();
    test_reset_mid_shift();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
